// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits a beat-count transfer into INCR bursts (MAX_BURST / 4 KB).
// Optional BURST_RRESP_CHECK_EN: error responses set err and end the transfer after the burst.
module axi_burst_reader #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_beats,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rlast,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SZ = $clog2(DATA_W / 8);
    localparam int CW = (LEN_W > 13) ? LEN_W : 13;
    localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << SZ;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  rem_dec;
    logic [8:0]        blen_q;
    logic [8:0]        blen;
    logic              done_q, err_q, abort_q;
    logic [CW-1:0]     to4k, rem_x, cap, blen_c;
    logic              accept, beat, last_beat, beat_err, stop, finish;
    logic              unused_bits;

    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;

    // Burst length from the live counters; they hold still while in ADDR.
    always_comb begin
        to4k   = CW'((13'd4096 - {1'b0, addr_q[11:0]}) >> SZ);
        rem_x  = CW'(rem_q);
        cap    = CW'(MAX_BURST);
        blen_c = (rem_x < cap) ? rem_x : cap;
        if (to4k < blen_c) blen_c = to4k;
        blen   = blen_c[8:0];
    end

`ifdef BURST_RRESP_CHECK_EN
    assign beat_err    = beat && (m_axi_rresp != 2'b00);
    assign unused_bits = ^blen_c[CW-1:9];
`else
    assign beat_err    = 1'b0;
    assign unused_bits = ^{blen_c[CW-1:9], m_axi_rresp};
`endif

    assign accept    = (state_q == IDLE) && cmd_valid && !done_q;
    assign beat      = (state_q == DATA) && m_axi_rvalid && out_ready;
    assign last_beat = beat && m_axi_rlast;
    assign rem_dec   = rem_q - LEN_W'(1);
    assign stop      = abort_q || beat_err;
    assign finish    = last_beat && ((rem_dec == '0) || stop);

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_rready  = 1'b0;
        out_valid     = 1'b0;
        out_data      = '0;
        out_last      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = !done_q;
                if (accept && (cmd_beats != '0)) state_d = ADDR;
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = addr_q;
                m_axi_arlen   = 8'(blen - 9'd1);
                if (m_axi_arready) state_d = DATA;
            end
            DATA: begin
                m_axi_rready = out_ready;
                out_valid    = m_axi_rvalid;
                out_data     = m_axi_rdata;
                out_last     = m_axi_rlast && ((rem_q == LEN_W'(1)) || stop);
                if (last_beat) state_d = finish ? IDLE : ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (accept && (cmd_beats == '0)) || finish;
            if (accept) begin
                addr_q  <= cmd_addr & ALIGN;
                rem_q   <= cmd_beats;
                err_q   <= 1'b0;
                abort_q <= 1'b0;
            end
            if ((state_q == ADDR) && m_axi_arready) blen_q <= blen;
            if (beat) rem_q <= rem_dec;
            if (beat_err) begin
                err_q   <= 1'b1;
                abort_q <= 1'b1;
            end
            if (last_beat) addr_q <= addr_q + (ADDR_W'(blen_q) << SZ);
            if (finish) begin
                rem_q   <= '0;
                abort_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Self-checking bench for axi_burst_reader: table vectors, corner sequences and
// randomized transfers checked against a burst-splitting reference model.
module tb_axi_burst_reader;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MB = 16;
    localparam int LW = 16;
`ifdef BURST_RRESP_CHECK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic          clk, rst_n;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_beats;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, out_ready;
    logic          busy, done, err;

    axi_burst_reader #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
        .m_axi_rready(m_axi_rready),
        .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'h5a5a_c3c3, a};
    endfunction

    // Reference model outputs
    logic [31:0] exp_ar_addr[$];
    int          exp_ar_len[$];
    logic [31:0] obs_ar_addr[$];
    int          obs_ar_len[$];
    int          n_exp;
    bit          exp_err;
    logic [31:0] start_al;

    task automatic build_model(input logic [31:0] addr, input int beats,
                               input int err_at);
        logic [31:0] a;
        int rem, pos, b, to4k;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        a = addr & ~32'h7;
        start_al = a;
        rem = beats;
        pos = 0;
        n_exp = 0;
        exp_err = 1'b0;
        while (rem > 0) begin
            to4k = (4096 - int'(a % 4096)) / 8;
            b = rem;
            if (b > MB) b = MB;
            if (b > to4k) b = to4k;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(b - 1);
            n_exp += b;
            if (RCHK && err_at >= pos && err_at < pos + b) begin
                exp_err = 1'b1;
                break;
            end
            pos += b;
            a += 32'(b * 8);
            rem -= b;
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_beats = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_arvalid"}, m_axi_arvalid, 0);
        check({tag, "_araddr"}, m_axi_araddr, 0);
        check({tag, "_arlen"}, m_axi_arlen, 0);
        check({tag, "_arsize"}, m_axi_arsize, 3);
        check({tag, "_arburst"}, m_axi_arburst, 1);
        check({tag, "_rready"}, m_axi_rready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // mode 0: random handshakes; 1: always ready; 2: AR stall + out_ready toggle
    task automatic run_xfer(input logic [31:0] addr, input int beats,
                            input int err_at, input int mode, input int rst_at);
        bit sent, fin, s_act, prev_arv;
        logic [31:0] s_addr, prev_addr;
        logic [7:0] prev_len;
        int s_len, s_beat, idx, ar_wait, acc_cyc, last_cyc, budget;
        build_model(addr, beats, err_at);
        obs_ar_addr.delete();
        obs_ar_len.delete();
        sent = 0; fin = 0; s_act = 0; prev_arv = 0;
        s_addr = '0; prev_addr = '0; prev_len = '0;
        s_len = 0; s_beat = 0; idx = 0; ar_wait = 0;
        acc_cyc = -10; last_cyc = -10;
        budget = beats * 10 + 200;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = !sent;
            cmd_addr = addr;
            cmd_beats = LW'(beats);
            case (mode)
                1: m_axi_arready = 1'b1;
                2: m_axi_arready = (ar_wait >= 5);
                default: m_axi_arready = ($urandom_range(0, 2) != 0);
            endcase
            m_axi_rvalid = s_act && (mode != 0 || $urandom_range(0, 3) != 0);
            m_axi_rdata = s_act ? pat(s_addr + 32'(s_beat * 8)) : 64'($urandom);
            m_axi_rlast = s_act && (s_beat == s_len);
            m_axi_rresp = (s_act && idx == err_at) ? 2'b10 : 2'b00;
            case (mode)
                1: out_ready = 1'b1;
                2: out_ready = cyc[0];
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (rst_at >= 0 && sent && idx == rst_at) begin
                check("mid_busy", busy, 1);
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                idle_inputs();
                rst_n = 1'b1;
                return;
            end
            #1;
            if (done) begin
                check("done_timing", cyc,
                      (beats == 0) ? acc_cyc + 1 : last_cyc + 1);
                fin = 1;
            end
            if (cyc == acc_cyc + 1) check("busy", busy, beats != 0);
            if (cmd_valid && cmd_ready) begin
                sent = 1;
                acc_cyc = cyc;
            end
            if (m_axi_arvalid) begin
                if (prev_arv) begin
                    check("araddr_stable", m_axi_araddr, prev_addr);
                    check("arlen_stable", m_axi_arlen, prev_len);
                end
                if (m_axi_arready) begin
                    obs_ar_addr.push_back(m_axi_araddr);
                    obs_ar_len.push_back(int'(m_axi_arlen));
                    if (exp_ar_addr.size() == 0) begin
                        check("extra_ar", m_axi_araddr, 32'hffff_ffff);
                    end else begin
                        check("araddr", m_axi_araddr, exp_ar_addr.pop_front());
                        check("arlen", m_axi_arlen, exp_ar_len.pop_front());
                    end
                    s_act = 1; s_addr = m_axi_araddr;
                    s_len = int'(m_axi_arlen); s_beat = 0;
                    prev_arv = 0; ar_wait = 0;
                end else begin
                    prev_arv = 1; prev_addr = m_axi_araddr;
                    prev_len = m_axi_arlen; ar_wait++;
                end
            end else begin
                prev_arv = 0;
            end
            if (m_axi_rvalid) begin
                check("rready_mirror", m_axi_rready, out_ready);
                check("out_valid", out_valid, 1);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                if (idx < n_exp) begin
                    check("out_data", out_data, pat(start_al + 32'(idx * 8)));
                    check("out_last", out_last, idx == n_exp - 1);
                end else begin
                    check("extra_beat", idx, n_exp);
                end
                if (idx == n_exp - 1) last_cyc = cyc;
                idx++;
                if (m_axi_rlast) s_act = 0;
                else s_beat++;
            end
        end
        if (!fin) check("timeout_no_done", 0, 1);
        check("beat_count", idx, n_exp);
        check("ars_missing", exp_ar_addr.size(), 0);
        check("err_flag", err, exp_err);
        @(negedge clk);
        idle_inputs();
    endtask

    typedef struct {
        logic [31:0] addr;
        int          beats;
        int          n_ar;
        logic [31:0] ar0;
        int          len0;
        logic [31:0] arn;
        int          lenn;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{32'h0000_1000,  8, 1, 32'h1000, 7,  32'h1000, 7};
        vt[1] = '{32'h0000_2000, 40, 3, 32'h2000, 15, 32'h2100, 7};
        vt[2] = '{32'h0000_0FE0,  8, 2, 32'h0FE0, 3,  32'h1000, 3};
        vt[3] = '{32'h0000_0FE3,  8, 2, 32'h0FE0, 3,  32'h1000, 3};
        vt[4] = '{32'h0000_3FF8,  2, 2, 32'h3FF8, 0,  32'h4000, 0};
        vt[5] = '{32'h0000_5000, 16, 1, 32'h5000, 15, 32'h5000, 15};
        vt[6] = '{32'h0000_5000, 17, 2, 32'h5000, 15, 32'h5080, 0};

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vt[i].addr, vt[i].beats, -1, 1, -1);
            check("tbl_n_ar", obs_ar_addr.size(), vt[i].n_ar);
            if (obs_ar_addr.size() > 0) begin
                check("tbl_ar0", obs_ar_addr[0], vt[i].ar0);
                check("tbl_len0", obs_ar_len[0], vt[i].len0);
                check("tbl_arn", obs_ar_addr[$], vt[i].arn);
                check("tbl_lenn", obs_ar_len[$], vt[i].lenn);
            end
        end

        run_xfer(32'h0000_6000, 20, -1, 2, -1);
        check("stall_n_ar", obs_ar_addr.size(), 2);

        run_xfer(32'h0000_7000, 0, -1, 1, -1);
        check("zero_n_ar", obs_ar_addr.size(), 0);

        run_xfer(32'h0000_2000, 40, 2, 1, -1);
        check("rresp_n_ar", obs_ar_addr.size(), RCHK ? 1 : 3);
        run_xfer(32'h0000_2000, 4, -1, 1, -1);

        run_xfer(32'h0000_8000, 40, -1, 1, 5);
        run_xfer(32'h0000_8000, 8, -1, 1, -1);

        for (int i = 0; i < 25; i++) begin
            run_xfer($urandom & 32'h7fff_ffff, $urandom_range(0, 70),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1,
                     0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
